// File: rtl/phase_sweep_gen_pkg.sv
// phase_sweep_gen_pkg: shared types and default widths for the phase sweep generator
package phase_sweep_gen_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/phase_sweep_gen_if.sv
// phase_sweep_gen_if: sweep control plus phase stream bundle between a controller and the generator
interface phase_sweep_gen_if
    import phase_sweep_gen_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

    logic                   start;
    logic                   abort;
    logic [PHASE_WIDTH-1:0] phase_init;
    logic [PHASE_WIDTH-1:0] fcw_start;
    logic [PHASE_WIDTH-1:0] fcw_step;
    logic [COUNT_WIDTH-1:0] num_samples;
    logic                   out_valid;
    logic                   out_ready;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, phase_init, fcw_start, fcw_step, num_samples, out_ready,
        input  out_valid, phase, busy, done
    );

    modport slave (
        input  start, abort, phase_init, fcw_start, fcw_step, num_samples, out_ready,
        output out_valid, phase, busy, done
    );

endinterface

// File: rtl/phase_sweep_gen.sv
// phase_sweep_gen: linear-chirp phase accumulator emitting a valid/ready phase stream for a sine LUT
module phase_sweep_gen
    import phase_sweep_gen_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    phase_sweep_gen_if.slave bus
);

    sweep_state_t           state;
    sweep_state_t           state_nxt;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] fcw_q;
    logic [PHASE_WIDTH-1:0] step_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] num_q;
    logic                   abort_pend;
    logic                   accept;
    logic                   last;
    logic                   finish;

    // A beat is always on offer in RUN, so an abort just waits for the next accept to close the sweep
    always_comb begin
        accept    = state == RUN && bus.out_ready;
        last      = num_q != '0 && count_q + COUNT_WIDTH'(1) == num_q;
        finish    = accept && (last || bus.abort || abort_pend);
        state_nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
                    state == RUN  ? (finish ? DONE : RUN) : IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Sweep parameters latch on start; phase and FCW advance once per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            fcw_q      <= '0;
            step_q     <= '0;
            count_q    <= '0;
            num_q      <= '0;
            abort_pend <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            phase_q    <= bus.phase_init;
            fcw_q      <= bus.fcw_start;
            step_q     <= bus.fcw_step;
            num_q      <= bus.num_samples;
            count_q    <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (accept) begin
                phase_q <= phase_q + fcw_q;
                fcw_q   <= fcw_q + step_q;
                count_q <= count_q + COUNT_WIDTH'(1);
            end
            abort_pend <= state == RUN && !finish && (abort_pend || bus.abort);
        end
    end

    assign bus.out_valid = state == RUN;
    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE;
    assign bus.phase     = phase_q;

endmodule

// File: tb/tb_phase_sweep_gen.sv
// tb_phase_sweep_gen: directed and randomized sweeps checked against a closed-form phase model
module tb_phase_sweep_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    phase_sweep_gen_if #(.PHASE_WIDTH(32), .COUNT_WIDTH(16)) bus ();

    phase_sweep_gen #(.PHASE_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Phase of beat k: init + k*fcw0 + step*k(k-1)/2, modulo 2^32
    function automatic logic [31:0] model_phase(input logic [31:0] pi, input logic [31:0] fs,
                                                input logic [31:0] st, input int k);
        logic [31:0] kk;
        logic [31:0] tri_n;
        kk    = 32'(k);
        tri_n = 32'((longint'(k) * longint'(k - 1)) / 2);
        return pi + fs * kk + st * tri_n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string name, input logic [31:0] pi, input logic [31:0] fs,
                         input logic [31:0] st, input logic [15:0] n, input int rdy_pct,
                         input int abort_after, input int stall_at, input int stall_len);
        int k = 0;
        int cyc = 0;
        int stalled = 0;
        int expect_n;
        bit fin = 0;
        bit acc = 0;
        bit aborted = 0;
        expect_n = (abort_after >= 0 && (n == 0 || abort_after + 1 < int'(n))) ? abort_after + 1 : int'(n);
        bus.phase_init  = pi;
        bus.fcw_start   = fs;
        bus.fcw_step    = st;
        bus.num_samples = n;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!fin && cyc < 4000) begin
            if (bus.done) begin
                fin = 1;
            end else begin
                check({name, "/valid"}, 64'(bus.out_valid), 64'(1));
                check({name, "/busy"}, 64'(bus.busy), 64'(1));
                check({name, "/phase"}, 64'(bus.phase), 64'(model_phase(pi, fs, st, k)));
                if (k == stall_at && stalled < stall_len) begin
                    bus.out_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.out_ready = $urandom_range(99) < rdy_pct;
                end
                bus.abort = !aborted && k == abort_after;
                if (bus.abort)
                    aborted = 1;
                if (cyc == 2) begin
                    bus.start       = 1'b1;
                    bus.phase_init  = $urandom;
                    bus.fcw_start   = $urandom;
                    bus.fcw_step    = $urandom;
                    bus.num_samples = 16'd1;
                end
                acc = bus.out_ready;
                if (acc)
                    k++;
                tick();
                cyc++;
                bus.abort = 1'b0;
                bus.start = 1'b0;
            end
        end
        check({name, "/finished"}, 64'(fin), 64'(1));
        check({name, "/beats"}, 64'(k), 64'(expect_n));
        check({name, "/done_after_accept"}, 64'(acc), 64'(1));
        check({name, "/done_valid"}, 64'(bus.out_valid), 64'(0));
        check({name, "/done_busy"}, 64'(bus.busy), 64'(0));
        bus.out_ready = 1'b0;
        tick();
        check({name, "/done_pulse"}, 64'(bus.done), 64'(0));
        check({name, "/idle_valid"}, 64'(bus.out_valid), 64'(0));
        check({name, "/idle_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.out_ready   = 1'b0;
        bus.phase_init  = '0;
        bus.fcw_start   = '0;
        bus.fcw_step    = '0;
        bus.num_samples = '0;
        #1;
        check("reset/valid", 64'(bus.out_valid), 64'(0));
        check("reset/busy", 64'(bus.busy), 64'(0));
        check("reset/done", 64'(bus.done), 64'(0));
        check("reset/phase", 64'(bus.phase), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        sweep("basic", 32'h0, 32'h1000_0000, 32'h0, 16'd4, 100, -1, -1, 0);
        sweep("chirp", 32'h0, 32'h100, 32'h10, 16'd3, 100, -1, -1, 0);
        sweep("wrap", 32'hF000_0000, 32'h2000_0000, 32'h0, 16'd2, 100, -1, -1, 0);
        sweep("backpressure", 32'h100, 32'h3000_0000, 32'h5, 16'd8, 100, -1, 3, 3);
        sweep("abort_held", 32'h0, 32'h0100_0000, 32'h0, 16'd0, 100, 5, 5, 3);
        sweep("abort_last", 32'h0, 32'h10, 32'h0, 16'd4, 100, 3, -1, 0);
        sweep("neg_step", 32'h8000_0000, 32'h0400_0000, 32'hFFF0_0000, 16'd12, 70, -1, 4, 2);
        sweep("continuous", $urandom, $urandom, $urandom, 16'd0, 60, 12, -1, 0);

        for (int i = 0; i < 8; i++)
            sweep("random", $urandom, $urandom, $urandom, 16'($urandom_range(1, 20)),
                  int'($urandom_range(30, 100)), (i % 2 == 1) ? int'($urandom_range(0, 15)) : -1,
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 4)));

        bus.phase_init  = 32'h1234;
        bus.fcw_start   = 32'h0100_0000;
        bus.fcw_step    = 32'h0;
        bus.num_samples = 16'd0;
        bus.start       = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("pre_reset/valid", 64'(bus.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset/valid", 64'(bus.out_valid), 64'(0));
        check("async_reset/busy", 64'(bus.busy), 64'(0));
        check("async_reset/phase", 64'(bus.phase), 64'(0));
        check("async_reset/done", 64'(bus.done), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_reset/valid", 64'(bus.out_valid), 64'(0));
            check("post_reset/busy", 64'(bus.busy), 64'(0));
        end
        sweep("restart", $urandom, $urandom, $urandom, 16'd6, 80, -1, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_sweep_gen.md
PHASE_SWEEP_GEN -- requirements
Module: phase_sweep_gen

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32, phase and frequency-control-word (FCW) width in bits.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, width of the sample-count field.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  request to end the active sweep early.
REQ-007 SHALL have port phase_init  input  PHASE_WIDTH  first phase emitted; sampled with start.
REQ-008 SHALL have port fcw_start  input  PHASE_WIDTH  initial FCW, unsigned; sampled with start.
REQ-009 SHALL have port fcw_step  input  PHASE_WIDTH  signed per-sample FCW increment; sampled with start.
REQ-010 SHALL have port num_samples  input  COUNT_WIDTH  beats to emit; 0 = continuous; sampled with start.
REQ-011 SHALL have port out_valid  output  1  phase beat available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port phase  output  PHASE_WIDTH  phase word for downstream LUT indexing.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse on sweep completion or abort.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1, latch phase_init/fcw_start/fcw_step/num_samples, load phase=phase_init, fcw=fcw_start, count=0, and enter RUN; out_valid asserts the following cycle.
REQ-018 SHALL ignore start while in RUN or DONE.
REQ-019 SHALL, in RUN, hold out_valid=1 and keep phase stable until out_valid&&out_ready.
REQ-020 SHALL, on each accepted beat, update phase<=phase+fcw and fcw<=fcw+fcw_step, both modulo 2^PHASE_WIDTH (wrap, no saturation), and increment count.
REQ-021 SHALL sustain one beat per cycle while out_ready=1 (no bubbles).
REQ-022 SHALL, when num_samples!=0 and the accepted beat is number num_samples, deassert out_valid and enter DONE on the next edge.
REQ-023 SHALL, when num_samples=0, run until abort; count wraps silently.
REQ-024 SHALL register abort as pending in RUN; with no beat outstanding or once the outstanding beat is accepted, enter DONE; a presented beat is never withdrawn unaccepted.
REQ-025 SHALL treat abort coincident with the final accept as normal completion (single done pulse).
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle, out_valid=0, then return to IDLE.
REQ-027 SHALL hold busy=1 exactly while in RUN.

Reset
REQ-028 SHALL, on rst_n=0, immediately force IDLE, out_valid=0, phase=0, busy=0, done=0, clear internal fcw/count/abort-pending, regardless of state.
REQ-029 SHALL, after reset deasserts mid-sweep, emit no beat until a new start.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, RUN, DONE) in the shared DSP package.
REQ-031 SHALL be a single module, no sub-modules; phase output connects directly to the sine LUT phase/valid/ready input.

Verification
REQ-032 SHALL test basic sweep: phase_init=0, fcw_start=0x1000_0000, fcw_step=0, num_samples=4, out_ready=1 -> phases 0, 0x1000_0000, 0x2000_0000, 0x3000_0000; done one cycle after last accept.
REQ-033 SHALL test chirp: phase_init=0, fcw_start=0x100, fcw_step=0x10, num_samples=3 -> phases 0x0, 0x100, 0x210.
REQ-034 SHALL test wrap: phase_init=0xF000_0000, fcw_start=0x2000_0000, num_samples=2 -> phases 0xF000_0000, 0x1000_0000.
REQ-035 SHALL test backpressure: out_ready low 3 cycles mid-sweep -> phase constant, out_valid high, no beat lost or duplicated.
REQ-036 SHALL test abort: num_samples=0, abort asserted while out_valid=1 and out_ready=0 -> beat held until accepted, then done pulse, IDLE; start during RUN ignored.
REQ-037 SHALL test reset mid-sweep: rst_n low in RUN -> out_valid/busy 0 asynchronously; no beats until new start.
